// File: rtl/rx_string_checker.sv
// rx_string_checker: checks UART-received bytes against a NUL-terminated string in synchronous ROM.
// Reports pass/fail with a one-hot cause (mismatch, timeout, overrun) and the offending bytes.
module rx_string_checker #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000,
   parameter logic [7:0]  MAX_LEN        = 8'd255
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       check_start,
   input  logic [7:0] start_addr,
   output logic [7:0] addr,
   input  logic [7:0] data,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic       check_done,
   output logic       check_pass,
   output logic [2:0] err,
   output logic [7:0] byte_count,
   output logic [7:0] exp_byte,
   output logic [7:0] got_byte
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, WAIT_RX, COMPARE, DONE} state_t;

   state_t      state, state_next;
   logic        rx_done_last, rx_pending;
   logic [7:0]  rx_hold, exp_reg;
   logic [23:0] tcnt;
   logic        rx_edge, go, ovr, timeout_hit, match;

   assign rx_edge     = rx_done && !rx_done_last;
   assign go          = check_start && state != IDLE && state != DONE;
   // a byte landing during COMPARE refills the holding slot that COMPARE is freeing
   assign ovr         = go && rx_edge && rx_pending && state != COMPARE;
   assign timeout_hit = TIMEOUT_CYCLES != 24'd0 && tcnt == TIMEOUT_CYCLES - 24'd1;
   assign match       = rx_hold == exp_reg;

   always_ff @(posedge CLOCK_50 or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_next;

   always_comb begin
      state_next = state;
      if (state == IDLE) state_next = check_start ? FETCH : IDLE;
      else if (state == DONE) state_next = check_start ? DONE : IDLE;
      else if (!check_start) state_next = IDLE;
      else if (ovr) state_next = DONE;
      else if (state == FETCH) state_next = WAIT_ROM;
      else if (state == WAIT_ROM) state_next = (data == 8'h00 || byte_count == MAX_LEN) ? DONE : WAIT_RX;
      else if (state == WAIT_RX) state_next = rx_pending ? COMPARE : timeout_hit ? DONE : WAIT_RX;
      else state_next = match ? FETCH : DONE;
   end

   always_comb begin
      check_done = state == DONE;
      check_pass = state == DONE && err == 3'b000;
   end

   always_ff @(posedge CLOCK_50 or negedge reset)
      if (!reset) begin
         rx_done_last <= 1'b1;
         rx_pending   <= 1'b0;
         rx_hold      <= 8'h00;
         exp_reg      <= 8'h00;
         tcnt         <= 24'd0;
         addr         <= 8'h00;
         err          <= 3'b000;
         byte_count   <= 8'h00;
         exp_byte     <= 8'h00;
         got_byte     <= 8'h00;
      end else begin
         rx_done_last <= rx_done;
         if (state == IDLE && check_start) begin
            addr       <= start_addr;
            err        <= 3'b000;
            byte_count <= 8'h00;
            exp_byte   <= 8'h00;
            got_byte   <= 8'h00;
            rx_pending <= 1'b0;
         end else if (go) begin
            if (rx_edge) begin
               rx_hold    <= rx_data;
               rx_pending <= 1'b1;
            end
            if (ovr) err <= 3'b100;
            else if (state == WAIT_ROM) begin
               exp_reg <= data;
               tcnt    <= 24'd0;
               if (data != 8'h00 && byte_count == MAX_LEN) err <= 3'b100;
            end else if (state == WAIT_RX) begin
               tcnt <= tcnt + 24'd1;
               if (!rx_pending && timeout_hit) err <= 3'b010;
            end else if (state == COMPARE) begin
               rx_pending <= rx_edge;
               if (match) begin
                  byte_count <= byte_count + 8'd1;
                  addr       <= addr + 8'd1;
               end else begin
                  err      <= 3'b001;
                  exp_byte <= exp_reg;
                  got_byte <= rx_hold;
               end
            end
         end
      end

endmodule

// File: tb/tb_rx_string_checker.sv
// tb_rx_string_checker: directed loopback scenarios against a synchronous ROM model.
module tb_rx_string_checker;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b0;
   logic       check_start = 1'b0;
   logic [7:0] start_addr = 8'h00;
   logic [7:0] addr, data;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       check_done, check_pass;
   logic [2:0] err;
   logic [7:0] byte_count, exp_byte, got_byte;
   logic [7:0] rom [256];
   int         checks = 0;
   int         errors = 0;

   rx_string_checker #(.TIMEOUT_CYCLES(24'd1000), .MAX_LEN(8'd4)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .check_start(check_start), .start_addr(start_addr),
      .addr(addr), .data(data), .rx_data(rx_data), .rx_done(rx_done),
      .check_done(check_done), .check_pass(check_pass), .err(err), .byte_count(byte_count),
      .exp_byte(exp_byte), .got_byte(got_byte)
   );

   always #10 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) data <= rom[addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic start(input logic [7:0] a);
      start_addr  = a;
      check_start = 1'b1;
      tick(1);
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick(1);
      rx_done = 1'b0;
      tick(7);
   endtask

   task automatic wait_done(input int limit);
      int i = 0;
      while (!check_done && i < limit) begin
         tick(1);
         i++;
      end
      @(negedge CLOCK_50);
      check("done_seen", {31'd0, check_done}, 32'd1);
   endtask

   task automatic result(input string tag, input logic pass, input logic [2:0] e,
                         input logic [7:0] bc, input logic [7:0] eb, input logic [7:0] gb);
      check({tag, "_pass"}, {31'd0, check_pass}, {31'd0, pass});
      check({tag, "_err"}, {29'd0, err}, {29'd0, e});
      check({tag, "_count"}, {24'd0, byte_count}, {24'd0, bc});
      check({tag, "_exp"}, {24'd0, exp_byte}, {24'd0, eb});
      check({tag, "_got"}, {24'd0, got_byte}, {24'd0, gb});
   endtask

   task automatic release_check();
      check_start = 1'b0;
      tick(1);
      check("done_drop", {31'd0, check_done}, 32'd0);
      tick(1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      rom[8'h00] = 8'h48; rom[8'h01] = 8'h69;
      rom[8'h10] = 8'h48; rom[8'h11] = 8'h45; rom[8'h12] = 8'h4C; rom[8'h13] = 8'h4C; rom[8'h14] = 8'h4F;
      rom[8'h20] = 8'h41; rom[8'h21] = 8'h42; rom[8'h22] = 8'h43; rom[8'h23] = 8'h44;
      rom[8'hFF] = 8'h5A;

      tick(3);
      check("rst_addr", {24'd0, addr}, 32'd0);
      check("rst_done", {31'd0, check_done}, 32'd0);
      result("rst", 1'b0, 3'b000, 8'd0, 8'd0, 8'd0);
      reset = 1'b1;
      tick(2);

      start(8'h00); send(8'h48); send(8'h69); wait_done(20);
      result("hi", 1'b1, 3'b000, 8'd2, 8'd0, 8'd0);
      check_start = 1'b0;
      tick(1);
      check("hi_drop", {31'd0, check_done}, 32'd0);
      check("hi_held", {24'd0, byte_count}, 32'd2);
      tick(1);

      start(8'h00); send(8'h48); send(8'h6F); wait_done(20);
      result("mis", 1'b0, 3'b001, 8'd1, 8'h69, 8'h6F);
      release_check();

      start(8'h30);
      for (int i = 0; i < 4 && !check_done; i++) tick(1);
      @(negedge CLOCK_50);
      check("empty_fast", {31'd0, check_done}, 32'd1);
      result("empty", 1'b1, 3'b000, 8'd0, 8'd0, 8'd0);
      release_check();

      start(8'h00); send(8'h48);
      tick(900);
      check("to_early", {31'd0, check_done}, 32'd0);
      wait_done(200);
      result("to", 1'b0, 3'b010, 8'd1, 8'd0, 8'd0);
      release_check();

      start(8'h10); send(8'h48); send(8'h45); send(8'h4C); send(8'h4C); wait_done(20);
      result("maxlen", 1'b0, 3'b100, 8'd4, 8'd0, 8'd0);
      release_check();

      start(8'h20); send(8'h41); send(8'h42); send(8'h43); send(8'h44); wait_done(20);
      result("len4", 1'b1, 3'b000, 8'd4, 8'd0, 8'd0);
      release_check();

      start(8'hFF); send(8'h5A); send(8'h48); send(8'h69); wait_done(20);
      result("wrap", 1'b1, 3'b000, 8'd3, 8'd0, 8'd0);
      check("wrap_addr", {24'd0, addr}, 32'd2);
      release_check();

      start(8'h00);
      rx_data = 8'h48; rx_done = 1'b1; tick(1);
      rx_done = 1'b0; tick(1);
      rx_done = 1'b1; tick(1);
      rx_done = 1'b0;
      wait_done(20);
      result("ovr", 1'b0, 3'b100, 8'd0, 8'd0, 8'd0);
      release_check();

      start(8'h00); send(8'h48);
      check("mid_count", {24'd0, byte_count}, 32'd1);
      #3 reset = 1'b0; check_start = 1'b0;
      #1;
      check("arst_addr", {24'd0, addr}, 32'd0);
      check("arst_done", {31'd0, check_done}, 32'd0);
      result("arst", 1'b0, 3'b000, 8'd0, 8'd0, 8'd0);
      tick(1);
      reset = 1'b1;
      tick(1);

      start(8'h00); send(8'h48);
      check_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLOCK_50);
         check("abort_done", {31'd0, check_done}, 32'd0);
      end
      tick(1);

      start(8'h00); send(8'h48); send(8'h69); wait_done(20);
      result("rerun", 1'b1, 3'b000, 8'd2, 8'd0, 8'd0);
      release_check();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
